half_stream_dot_feeder: RTL and testbench

- Source and sink for the half-precision stream multiply-accumulate engine.
- Holds one activation vector and a weight matrix, and drives (a, b) pairs with a valid strobe into the MAC, one vector per neuron, back to back.
- Collects the NEURONS dot-product results returned by the MAC into a readable result bank, then signals done.

---
 rtl/half_stream_dot_feeder.sv | 156 +++++++++++++++
 tb/tb_half_stream_dot_feeder.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/half_stream_dot_feeder.sv
// Activation/weight source and result sink for the half-precision stream MAC.
// Optional bias pair per neuron when HALF_FEEDER_BIAS_EN is defined.
module half_stream_dot_feeder #(
  parameter int BITS    = 16,
  parameter int LENGTH  = 10,
  parameter int NEURONS = 4,
  localparam int AW = $clog2(NEURONS*LENGTH),
  localparam int RW = (NEURONS > 1) ? $clog2(NEURONS) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_en,
  input  logic [1:0]      wr_sel,
  input  logic [AW-1:0]   wr_addr,
  input  logic [BITS-1:0] wr_data,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic            mac_valid,
  output logic [BITS-1:0] mac_a,
  output logic [BITS-1:0] mac_b,
  input  logic            res_valid,
  input  logic [BITS-1:0] res_data,
  input  logic [RW-1:0]   rd_addr,
  output logic [BITS-1:0] rd_data
);

`ifdef HALF_FEEDER_BIAS_EN
  localparam int PER = LENGTH + 1;
`else
  localparam int PER = LENGTH;
`endif
  localparam int IW = (PER > 1) ? $clog2(PER) : 1;
  localparam int LW = (LENGTH > 1) ? $clog2(LENGTH) : 1;
  localparam int CW = $clog2(NEURONS + 1);

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN, FINISH} state_t;

  state_t          state;
  logic [IW-1:0]   idx;
  logic [RW-1:0]   nrn;
  logic [AW-1:0]   w_ptr;
  logic [CW-1:0]   rcnt;
  logic            v1;
  logic [BITS-1:0] act_q, w_q;

  logic [BITS-1:0] act_mem [LENGTH];
  logic [BITS-1:0] w_mem   [NEURONS*LENGTH];
  logic [BITS-1:0] result  [NEURONS];
`ifdef HALF_FEEDER_BIAS_EN
  logic [BITS-1:0] bias_mem [NEURONS];
`endif

  logic issue, wr_ok, idx_last, wt_elem;

  assign issue    = (state == STREAM);
  assign wr_ok    = wr_en && (state == IDLE);
  assign idx_last = (int'(idx) == PER - 1);
  assign wt_elem  = (int'(idx) < LENGTH);
  assign rd_data  = result[rd_addr];

  // Memories are deliberately unreset; only the read pipeline is.
  always_ff @(posedge clk) begin
    if (wr_ok && wr_sel == 2'd0 && int'(wr_addr) < LENGTH)
      act_mem[wr_addr[LW-1:0]] <= wr_data;
    if (wr_ok && wr_sel == 2'd1 && int'(wr_addr) < NEURONS*LENGTH)
      w_mem[wr_addr] <= wr_data;
`ifdef HALF_FEEDER_BIAS_EN
    if (wr_ok && wr_sel == 2'd2 && int'(wr_addr) < NEURONS)
      bias_mem[wr_addr[RW-1:0]] <= wr_data;
`endif
    if (issue) begin
      if (wt_elem) begin
        act_q <= act_mem[idx[LW-1:0]];
        w_q   <= w_mem[w_ptr];
      end else begin
`ifdef HALF_FEEDER_BIAS_EN
        act_q <= BITS'(16'h3C00);
        w_q   <= bias_mem[nrn];
`else
        act_q <= '0;
        w_q   <= '0;
`endif
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1        <= 1'b0;
      mac_valid <= 1'b0;
      mac_a     <= '0;
      mac_b     <= '0;
    end else begin
      v1        <= issue;
      mac_valid <= v1;
      mac_a     <= v1 ? act_q : '0;
      mac_b     <= v1 ? w_q   : '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      idx   <= '0;
      nrn   <= '0;
      w_ptr <= '0;
      rcnt  <= '0;
      for (int i = 0; i < NEURONS; i++) result[i] <= '0;
    end else begin
      if (busy && res_valid && int'(rcnt) < NEURONS) begin
        result[rcnt[RW-1:0]] <= res_data;
        rcnt <= rcnt + CW'(1);
      end
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state <= STREAM;
            busy  <= 1'b1;
            idx   <= '0;
            nrn   <= '0;
            w_ptr <= '0;
            rcnt  <= '0;
          end
        end
        STREAM: begin
          if (wt_elem) w_ptr <= w_ptr + AW'(1);
          if (idx_last) begin
            idx <= '0;
            if (int'(nrn) == NEURONS - 1) state <= DRAIN;
            else nrn <= nrn + RW'(1);
          end else begin
            idx <= idx + IW'(1);
          end
        end
        DRAIN: begin
          // Let the read pipeline empty before declaring the run complete.
          if (int'(rcnt) == NEURONS && !v1 && !mac_valid) begin
            state <= FINISH;
            done  <= 1'b1;
            busy  <= 1'b0;
          end
        end
        FINISH: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_half_stream_dot_feeder.sv
// Self-checking bench for half_stream_dot_feeder: table-driven runs with a pair scoreboard.
// Honours HALF_FEEDER_BIAS_EN in its reference model.
module tb_half_stream_dot_feeder;
  localparam int BITS = 16, LENGTH = 10, NEURONS = 4;
  localparam int AW = $clog2(NEURONS*LENGTH);
  localparam int RW = $clog2(NEURONS);
`ifdef HALF_FEEDER_BIAS_EN
  localparam int PER = LENGTH + 1;
`else
  localparam int PER = LENGTH;
`endif

  logic clk = 1'b0, rst = 1'b1;
  logic wr_en = 1'b0, start = 1'b0, res_valid = 1'b0;
  logic [1:0] wr_sel = '0;
  logic [AW-1:0] wr_addr = '0;
  logic [BITS-1:0] wr_data = '0, res_data = '0;
  logic [RW-1:0] rd_addr = '0;
  logic busy, done, mac_valid;
  logic [BITS-1:0] mac_a, mac_b, rd_data;

  half_stream_dot_feeder #(.BITS(BITS), .LENGTH(LENGTH), .NEURONS(NEURONS)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
    .wr_data(wr_data), .start(start), .busy(busy), .done(done),
    .mac_valid(mac_valid), .mac_a(mac_a), .mac_b(mac_b),
    .res_valid(res_valid), .res_data(res_data), .rd_addr(rd_addr), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NEURONS-1:0][BITS-1:0] res;
    int rst_at;
  } run_vec_t;

  run_vec_t run_tbl [3];
  logic [BITS-1:0] act_m [LENGTH];
  logic [BITS-1:0] w_m [NEURONS*LENGTH];
  logic [BITS-1:0] bias_m [NEURONS];
  logic [BITS-1:0] last_res [NEURONS];
  logic [31:0] sbq [$];

  int checks = 0, errors = 0;
  int cyc = 0, first_v, last_v, nvalid, done_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (mac_valid) begin
      nvalid++;
      if (first_v < 0) first_v = cyc;
      last_v = cyc;
      if (sbq.size() == 0) chk("unexpected_pair", 32'd1, 32'd0);
      else begin
        logic [31:0] e;
        e = sbq.pop_front();
        chk("mac_a", {16'h0, mac_a}, {16'h0, e[31:16]});
        chk("mac_b", {16'h0, mac_b}, {16'h0, e[15:0]});
      end
    end else begin
      chk("idle_pair_zero", {mac_a, mac_b}, 32'h0);
    end
    if (done) begin
      done_cnt++;
      chk("busy_low_at_done", {31'h0, busy}, 32'h0);
    end
  end

  task automatic wr(input logic [1:0] sel, input int addr, input logic [BITS-1:0] d);
    wr_en = 1'b1; wr_sel = sel; wr_addr = AW'(addr); wr_data = d;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic do_run(input int v);
    bit aborted = 0, seen = 0;
    int done_k = -1;
    first_v = -1; last_v = -1; nvalid = 0; done_cnt = 0;
    sbq.delete();
    for (int n = 0; n < NEURONS; n++) begin
      for (int i = 0; i < LENGTH; i++) sbq.push_back({act_m[i], w_m[n*LENGTH+i]});
`ifdef HALF_FEEDER_BIAS_EN
      sbq.push_back({16'h3C00, bias_m[n]});
`endif
    end
    start = 1'b1;
    @(posedge clk); cyc = 0; #1;
    start = 1'b0;
    for (int k = 1; k <= 90; k++) begin
      if (k == 10) begin
        start = 1'b1; wr_en = 1'b1; wr_sel = 2'd0; wr_addr = '0; wr_data = 16'h0000;
      end
      for (int j = 0; j < NEURONS; j++)
        if (k == 15 + 10*j) begin res_valid = 1'b1; res_data = run_tbl[v].res[j]; end
      @(posedge clk); cyc = k; #1;
      start = 1'b0; wr_en = 1'b0; res_valid = 1'b0;
      if (k == 1) chk("busy_after_start", {31'h0, busy}, 32'h1);
      if (k == run_tbl[v].rst_at) begin
        rst = 1'b1; #1;
        chk("rst_mac_valid", {31'h0, mac_valid}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        for (int r = 0; r < NEURONS; r++) begin
          rd_addr = RW'(r); #1;
          chk("rst_result_cleared", {16'h0, rd_data}, 32'h0);
        end
        sbq.delete();
        aborted = 1;
        @(posedge clk); #1;
        rst = 1'b0;
        break;
      end
      if (done) begin seen = 1; done_k = k; break; end
    end
    if (!aborted) begin
      chk("done_seen", {31'h0, seen}, 32'h1);
      chk("done_cycle", done_k, 32'd46);
      repeat (3) @(posedge clk);
      #1;
      chk("done_pulses", done_cnt, 32'd1);
      chk("valid_count", nvalid, NEURONS*PER);
      chk("first_valid_cycle", first_v, 32'd2);
      chk("last_valid_cycle", last_v, 1 + NEURONS*PER);
      chk("scoreboard_empty", sbq.size(), 32'd0);
      for (int r = 0; r < NEURONS; r++) begin
        rd_addr = RW'(r); #1;
        chk("result_read", {16'h0, rd_data}, {16'h0, run_tbl[v].res[r]});
        last_res[r] = run_tbl[v].res[r];
      end
    end
  endtask

  initial begin
    run_tbl[0].res = {16'h4C00, 16'h4B00, 16'h4A00, 16'h4900}; run_tbl[0].rst_at = 0;
    run_tbl[1].res = {16'h1111, 16'h2222, 16'h3333, 16'h4444}; run_tbl[1].rst_at = 20;
    run_tbl[2].res = {16'h3800, 16'hB800, 16'h7BFF, 16'h0001}; run_tbl[2].rst_at = 0;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", {31'h0, busy}, 32'h0);
    chk("reset_done", {31'h0, done}, 32'h0);
    chk("reset_mac_valid", {31'h0, mac_valid}, 32'h0);
    chk("reset_mac_pair", {mac_a, mac_b}, 32'h0);
    for (int r = 0; r < NEURONS; r++) begin
      rd_addr = RW'(r); #1;
      chk("reset_result", {16'h0, rd_data}, 32'h0);
    end
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < LENGTH; i++) begin act_m[i] = 16'h3C00; wr(2'd0, i, act_m[i]); end
    for (int n = 0; n < NEURONS; n++)
      for (int i = 0; i < LENGTH; i++) begin
        w_m[n*LENGTH+i] = 16'h4000 + 16'(n);
        wr(2'd1, n*LENGTH+i, w_m[n*LENGTH+i]);
      end
`ifdef HALF_FEEDER_BIAS_EN
    for (int n = 0; n < NEURONS; n++) begin
      bias_m[n] = (n == 1) ? 16'hC000 : 16'h0100 + 16'(n);
      wr(2'd2, n, bias_m[n]);
    end
`else
    wr(2'd2, 0, 16'h0000);
`endif
    wr(2'd3, 0, 16'h0000);
    wr(2'd0, LENGTH, 16'h0000);

    do_run(0);

    done_cnt = 0;
    res_valid = 1'b1; res_data = 16'h5000;
    @(posedge clk); #1;
    res_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("idle_res_no_done", done_cnt, 32'd0);
    for (int r = 0; r < NEURONS; r++) begin
      rd_addr = RW'(r); #1;
      chk("idle_res_bank_unchanged", {16'h0, rd_data}, {16'h0, last_res[r]});
    end

    do_run(1);
    repeat (2) @(posedge clk);
    #1;
    do_run(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
